// File: rtl/linear_layer_start_fifo_srl_ctrl.sv
// Shift-register FIFO controller: DEPTH-word SRL store feeding a registered head-of-queue output.
// The output register makes a new word visible two edges after it is pushed into an empty block.
module linear_layer_start_fifo_srl_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] srl_q [DEPTH];
    logic [DATA_WIDTH-1:0] srl_d [DEPTH];
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      used_d;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  push, pop, load;

    // Next-state computation; the store is read before this edge's shift takes effect.
    always_comb begin
        push      = if_write & if_write_ce & full_n_q;
        pop       = if_read & if_read_ce & empty_n_q;
        raddr     = '0;
        load      = 1'b0;
        cnt_d     = cnt_q;
        empty_n_d = empty_n_q;
        dout_d    = dout_q;
        srl_d     = srl_q;

        if (cnt_q != '0) begin
            raddr = ADDR_WIDTH'(cnt_q - CNT_W'(1));
        end
        load = (cnt_q != '0) & (~empty_n_q | pop);

        if (push && !load) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (load && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (load) begin
            empty_n_d = 1'b1;
            dout_d    = srl_q[raddr];
        end else if (pop) begin
            empty_n_d = 1'b0;
        end

        if (push) begin
            srl_d[0] = if_din;
            for (int i = 1; i < DEPTH; i++) begin
                srl_d[i] = srl_q[i-1];
            end
        end

        used_d   = cnt_d + CNT_W'(empty_n_d);
        full_n_d = (used_d < CNT_W'(DEPTH));
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
            dout_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
            dout_q    <= dout_d;
        end
    end

    // Store contents need no reset: cnt_q gates every read.
    always_ff @(posedge clk) begin
        srl_q <= srl_d;
    end

    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;
    assign if_dout    = dout_q;

endmodule
